// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, 11-bit framing
// with odd parity, device ACK check and a whole-frame timeout.
module ps2_host_tx #(
    parameter int unsigned CLK_HZ     = 50_000_000,
    parameter int unsigned INHIBIT_US = 100,
    parameter int unsigned TIMEOUT_US = 15_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       busy,
    output logic       done,
    output logic       error,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe
);

    localparam int unsigned CYC_PER_US  = CLK_HZ / 1_000_000;
    localparam int unsigned INHIBIT_CYC = CYC_PER_US * INHIBIT_US;
    localparam int unsigned TIMEOUT_CYC = CYC_PER_US * TIMEOUT_US;
    localparam int unsigned CNT_MAX     = (INHIBIT_CYC > TIMEOUT_CYC) ? INHIBIT_CYC : TIMEOUT_CYC;
    localparam int unsigned CNT_W       = $clog2(CNT_MAX + 2);

    localparam logic [CNT_W-1:0] INHIBIT_LOAD = CNT_W'(INHIBIT_CYC);
    localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_INHIBIT   = 3'd1,
        ST_RTS       = 3'd2,
        ST_DATA      = 3'd3,
        ST_WAIT_IDLE = 3'd4
    } state_t;

    // Parity bit that makes the nine transmitted bits carry an odd number of ones.
    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       bit_q, bit_d;
    logic [7:0]       data_q, data_d;
    logic             par_q, par_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             error_q, error_d;
    logic             clk_oe_q, clk_oe_d;
    logic             dat_oe_q, dat_oe_d;

    logic [1:0]       clk_sync_q;
    logic [1:0]       dat_sync_q;
    logic             clk_prev_q;
    logic             clk_s;
    logic             dat_s;
    logic             fall_s;
    logic             expire_s;
    logic             abort_s;

    // Two-flop synchronizers on both pins plus the previous-clock register for edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            clk_sync_q <= 2'b11;
            dat_sync_q <= 2'b11;
            clk_prev_q <= 1'b1;
        end else begin
            clk_sync_q <= {clk_sync_q[0], ps2_clk_in};
            dat_sync_q <= {dat_sync_q[0], ps2_dat_in};
            clk_prev_q <= clk_sync_q[1];
        end
    end

    assign clk_s    = clk_sync_q[1];
    assign dat_s    = dat_sync_q[1];
    assign fall_s   = clk_prev_q & ~clk_s;
    assign expire_s = (cnt_q <= CNT_ONE);

    // Next-state and next-output logic; the shared counter times inhibit, then the frame.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        data_d   = data_q;
        par_d    = par_q;
        busy_d   = busy_q;
        clk_oe_d = clk_oe_q;
        dat_oe_d = dat_oe_q;
        done_d   = 1'b0;
        error_d  = 1'b0;
        abort_s  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                busy_d   = 1'b0;
                clk_oe_d = 1'b0;
                dat_oe_d = 1'b0;
                if (tx_start) begin
                    data_d   = tx_data;
                    par_d    = odd_parity(tx_data);
                    bit_d    = 4'd0;
                    cnt_d    = INHIBIT_LOAD;
                    busy_d   = 1'b1;
                    clk_oe_d = 1'b1;
                    state_d  = ST_INHIBIT;
                end else begin
                    state_d  = ST_IDLE;
                end
            end

            ST_INHIBIT: begin
                if (expire_s) begin
                    clk_oe_d = 1'b0;
                    dat_oe_d = 1'b1;
                    cnt_d    = TIMEOUT_LOAD;
                    state_d  = ST_RTS;
                end else begin
                    cnt_d    = cnt_q - CNT_ONE;
                end
            end

            ST_RTS: begin
                if (expire_s) begin
                    abort_s = 1'b1;
                end else begin
                    cnt_d   = cnt_q - CNT_ONE;
                    state_d = ST_DATA;
                end
            end

            ST_DATA: begin
                if (expire_s) begin
                    abort_s = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                    if (fall_s) begin
                        bit_d = bit_q + 4'd1;
                        if (bit_q <= 4'd7) begin
                            dat_oe_d = ~data_q[bit_q[2:0]];
                        end else if (bit_q == 4'd8) begin
                            dat_oe_d = ~par_q;
                        end else if (bit_q == 4'd9) begin
                            dat_oe_d = 1'b0;
                        end else if (!dat_s) begin
                            state_d = ST_WAIT_IDLE;
                        end else begin
                            abort_s = 1'b1;
                        end
                    end else begin
                        bit_d = bit_q;
                    end
                end
            end

            ST_WAIT_IDLE: begin
                if (expire_s) begin
                    abort_s = 1'b1;
                end else if (clk_s && dat_s) begin
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                    clk_oe_d = 1'b0;
                    dat_oe_d = 1'b0;
                    state_d  = ST_IDLE;
                end else begin
                    cnt_d    = cnt_q - CNT_ONE;
                end
            end

            default: begin
                busy_d   = 1'b0;
                clk_oe_d = 1'b0;
                dat_oe_d = 1'b0;
                state_d  = ST_IDLE;
            end
        endcase

        // Timeout or missing ACK: release both lines and report once.
        if (abort_s) begin
            error_d  = 1'b1;
            busy_d   = 1'b0;
            clk_oe_d = 1'b0;
            dat_oe_d = 1'b0;
            state_d  = ST_IDLE;
        end else begin
            error_d  = 1'b0;
        end
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            bit_q    <= 4'd0;
            data_q   <= 8'h00;
            par_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
            clk_oe_q <= 1'b0;
            dat_oe_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            data_q   <= data_d;
            par_q    <= par_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            error_q  <= error_d;
            clk_oe_q <= clk_oe_d;
            dat_oe_q <= dat_oe_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign error      = error_q;
    assign ps2_clk_oe = clk_oe_q;
    assign ps2_dat_oe = dat_oe_q;

endmodule
